// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A1;
  logic [31:0] A2;
  logic        req;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, A1, A2, req,
                  input  busy, stall_req, hi, lo);
  modport slave  (input  start, md_op, A1, A2, req,
                  output busy, stall_req, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; result computed at accept, held in shadow
// registers, and committed after MULT_CYCLES/DIV_CYCLES of busy (stalls requested meanwhile).
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  mdu_unit_if.slave   mdu
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic [31:0]    shd_hi_q, shd_hi_d, shd_lo_q, shd_lo_d;
  logic           dz_q, dz_d;

  md_op_e         op;
  logic           multi_op;
  logic           issue;
  logic signed [63:0] prod_s;
  logic [63:0]    prod_u;
  logic           sdiv;
  logic [31:0]    a_mag, b_mag, dvd, dvs, q_mag, r_mag, quo, rem;

  assign op       = md_op_e'(mdu.md_op);
  assign multi_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign issue    = mdu.start && !mdu.req;

  // Products are formed on explicitly extended 64-bit operands to keep widths exact.
  assign prod_s = $signed({{32{mdu.A1[31]}}, mdu.A1}) * $signed({{32{mdu.A2[31]}}, mdu.A2});
  assign prod_u = {32'd0, mdu.A1} * {32'd0, mdu.A2};

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign sdiv  = (op == OP_DIV);
  assign a_mag = mdu.A1[31] ? (~mdu.A1 + 32'd1) : mdu.A1;
  assign b_mag = mdu.A2[31] ? (~mdu.A2 + 32'd1) : mdu.A2;
  assign dvd   = sdiv ? a_mag : mdu.A1;
  assign dvs   = (mdu.A2 == 32'd0) ? 32'd1 : (sdiv ? b_mag : mdu.A2);
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;
  assign quo   = (sdiv && (mdu.A1[31] ^ mdu.A2[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = (sdiv && mdu.A1[31]) ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shd_hi_d = shd_hi_q;
    shd_lo_d = shd_lo_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          case (op)
            OP_MULT: begin
              {shd_hi_d, shd_lo_d} = prod_s;
              dz_d    = 1'b0;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = ST_BUSY;
            end
            OP_MULTU: begin
              {shd_hi_d, shd_lo_d} = prod_u;
              dz_d    = 1'b0;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              shd_hi_d = rem;
              shd_lo_d = quo;
              dz_d     = (mdu.A2 == 32'd0);
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = ST_BUSY;
            end
            OP_MTHI: hi_d = mdu.A1;
            OP_MTLO: lo_d = mdu.A1;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!dz_q) begin
            hi_d = shd_hi_q;
            lo_d = shd_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      shd_hi_q <= '0;
      shd_lo_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shd_hi_q <= shd_hi_d;
      shd_lo_q <= shd_lo_d;
      dz_q     <= dz_d;
    end
  end

  assign mdu.busy      = (state_q == ST_BUSY);
  assign mdu.stall_req = mdu.busy || (mdu.start && multi_op);
  assign mdu.hi        = hi_q;
  assign mdu.lo        = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: products, quotients, busy lengths, mthi/mtlo, req and reset.
module tb_mdu_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   n;

  mdu_unit_if bus ();
  mdu_unit dut (.clk(clk), .reset_n(reset_n), .mdu(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.req   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.A1    = a;
    bus.A2    = b;
    bus.req   = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    bus.A1 = '0;
    bus.A2 = '0;
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // signed mult
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    #1;
    chk("mult_stall_comb", {31'd0, bus.stall_req}, 32'd1);
    tick();
    idle_in();
    chk("mult_hi_hold", bus.hi, 32'd0);
    count_busy(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFA);
    tick();
    chk("mult_lo_stable", bus.lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    idle_in();
    count_busy(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_lo", bus.lo, 32'h00000001);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    tick();
    idle_in();
    count_busy(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    tick();
    idle_in();
    count_busy(n);
    chk("divovf_lo", bus.lo, 32'h80000000);
    chk("divovf_hi", bus.hi, 32'd0);

    issue(3'd5, 32'h1234, 32'd0);
    #1;
    chk("mthi_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    bus.req = 1'b1;
    tick();
    chk("mthi_req_hi", bus.hi, 32'h1234);
    issue(3'd6, 32'hABCD, 32'd0);
    tick();
    chk("mtlo_lo", bus.lo, 32'hABCD);

    // divide by zero keeps HI/LO
    issue(3'd4, 32'd5, 32'd0);
    tick();
    idle_in();
    count_busy(n);
    chk("dz_cycles", n, 32'd10);
    chk("dz_hi", bus.hi, 32'h1234);
    chk("dz_lo", bus.lo, 32'hABCD);

    // md_op 0 and 7 are no-ops
    issue(3'd0, 32'h1, 32'h1);
    #1;
    chk("nop0_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("nop0_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'd7, 32'h1, 32'h1);
    #1;
    chk("nop7_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("nop7_hi", bus.hi, 32'h1234);

    // req suppresses accept
    issue(3'd1, 32'd2, 32'd3);
    bus.req = 1'b1;
    #1;
    chk("req_stall", {31'd0, bus.stall_req}, 32'd1);
    tick();
    idle_in();
    chk("req_no_busy", {31'd0, bus.busy}, 32'd0);
    chk("req_lo", bus.lo, 32'hABCD);

    // start while busy ignored; req mid-op does not cancel
    issue(3'd3, 32'hFFFFFF9C, 32'd7);
    tick();
    idle_in();
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (n == 2) begin
        issue(3'd1, 32'd2, 32'd3);
      end else if (n == 4) begin
        idle_in();
        bus.req = 1'b1;
      end else begin
        idle_in();
      end
      n++;
      tick();
    end
    idle_in();
    chk("inflight_cycles", n, 32'd10);
    chk("inflight_lo", bus.lo, 32'hFFFFFFF2);
    chk("inflight_hi", bus.hi, 32'hFFFFFFFE);
    tick();
    chk("inflight_no_mult", {31'd0, bus.busy}, 32'd0);

    // async reset mid-op
    issue(3'd1, 32'd2, 32'd3);
    tick();
    idle_in();
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_lo", bus.lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
